eth_tx_arb: RTL and testbench
=============================

Name: eth_tx_arb

Overview:
- Frame-granular round-robin arbiter that shares the single MAC/IPv4/UDP transmit stack between REQ_N application streams.
- Grants one requester for a whole frame and muxes its beats to the TX stack, honouring TX backpressure.
- Enforces a minimum idle gap between frames and propagates TX cancel back to the owning requester.
- Sits between the application senders and the TX-side counterpart of the RX MAC/IPv4/UDP stack.

Parameters:
- DATA_W, 16, beat width in bits.
- KEEP_W, DATA_W/8, localparam; bytes per beat.
- LEN_W, $clog2(KEEP_W+1), width of the valid-byte count field.
- REQ_N, 4, number of requesters; must be >= 2.
- GAP_CYC, 2, minimum idle cycles between the last beat of one frame and the first beat of the next; 0 is legal.
- WDOG_CYC, 64, starvation limit; used only with the optional feature.

Ports:
- clk  in  1  clock.
- nreset  in  1  asynchronous active-low reset.
- req_valid_i  in  REQ_N  per-requester beat valid.
- req_data_i  in  REQ_N*DATA_W  per-requester data; requester r occupies bits [r*DATA_W +: DATA_W].
- req_len_i  in  REQ_N*LEN_W  per-requester valid bytes in the beat.
- req_last_i  in  REQ_N  last beat of the frame.
- req_ready_o  out  REQ_N  beat accepted when valid&ready.
- req_cancel_o  out  REQ_N  one-cycle pulse; the owning requester's frame was aborted.
- tx_ready_i  in  1  TX stack can take a beat.
- tx_cancel_i  in  1  TX stack or PHY aborts the current frame.
- tx_valid_o  out  1  beat valid to the TX stack.
- tx_start_o  out  1  first beat of a frame.
- tx_data_o  out  DATA_W  beat data.
- tx_len_o  out  LEN_W  valid bytes in the beat.
- tx_last_o  out  1  last beat of the frame.
- grant_o  out  $clog2(REQ_N)  current owner; meaningful only in XFER.
- busy_o  out  1  high when the state is not IDLE.

Behaviour:
Reset (nreset low, asynchronous):
- state=IDLE; gap counter=0; last_grant=REQ_N-1, so the first grant after reset goes to requester 0.
- All outputs are 0.

State machine:
- IDLE
  - If any req_valid_i is high, register grant = the first requester with valid high, searching from last_grant+1 with wrap to 0.
  - Go to XFER; set first_beat=1.
  - Nothing is accepted in the IDLE cycle, so there is one cycle of arbitration latency.
- XFER
  - tx_valid_o = req_valid_i[grant]; tx_data_o, tx_len_o and tx_last_o come combinationally from requester grant.
  - req_ready_o[grant] = tx_ready_i. All other req_ready_o bits are 0.
  - tx_start_o = tx_valid_o & first_beat. first_beat clears on the first accepted beat.
  - On an accepted beat with last set: last_grant<=grant. If GAP_CYC==0, go to IDLE; otherwise load the gap counter with GAP_CYC-1 and go to GAP.
- GAP
  - All tx outputs are 0.
  - The counter decrements each cycle; at 0 go to IDLE.

Cancel:
- tx_cancel_i high in XFER overrides everything in that cycle:
  - req_ready_o is all 0 and tx_valid_o=0.
  - req_cancel_o[grant] pulses for one cycle.
  - last_grant<=grant; go to GAP (or IDLE if GAP_CYC==0).
- tx_cancel_i in IDLE or GAP is ignored.

Boundary conditions:
- A single-beat frame (start and last on the same beat) is legal and asserts tx_start_o and tx_last_o together.
- The granted requester dropping valid mid-frame does not release the grant; the arbiter waits.
- A requester that is not granted never sees ready.
- If only one requester is active, it is re-granted after every gap.
- Data, len and last must be held stable while valid&!ready; this is a requester obligation, checked by an assertion.

Optional Feature:
- Macro: ETH_TX_ARB_WDOG_EN.
- Enabled:
  - A counter increments each XFER cycle in which req_valid_i[grant] is low, and clears on any accepted beat.
  - When it reaches WDOG_CYC, the arbiter behaves exactly as for tx_cancel_i and additionally pulses tx_last_o with tx_valid_o=0 so the TX stack closes the frame.
- Disabled: no counter is built, and a stalled owner holds the grant indefinitely.

Decomposition:
- Package eth_tx_arb_pkg holds:
  - state enum {IDLE, XFER, GAP}, 2 bits;
  - localparam GRANT_W = $clog2(REQ_N) helper.
- Sub-module rr_pick: combinational round-robin picker. Inputs: request vector and last_grant. Outputs: the winner index and an any-request flag. Reusable by a future RX dispatcher.

Test Plan:
- After reset, requesters 0 and 2 each present a 3-beat frame → 0 is granted first, its data appears one cycle later, then 2 cycles of gap, then 2 is granted; tx_start_o is high on the first beat of each frame only.
- All 4 requesters continuously valid with 1-beat frames → grant sequence 0,1,2,3,0 with a frame every 1+1+GAP_CYC cycles.
- Hold tx_ready_i low for 5 cycles mid-frame → no beat is lost or duplicated; req_ready_o[grant] follows tx_ready_i.
- Assert tx_cancel_i on beat 2 of requester 1's frame → req_cancel_o[1] is a one-cycle pulse; the next grant goes to 2 even if 1 is still valid.
- GAP_CYC=0 build → back-to-back frames are separated only by the IDLE arbitration cycle.
- With ETH_TX_ARB_WDOG_EN and WDOG_CYC=8, requester 3 drops valid after 1 beat → abort after 8 stall cycles with req_cancel_o[3]; without the macro the grant is held.

Source files
------------

// File: rtl/eth_tx_arb_pkg.sv
// Shared types for the frame-granular TX arbiter: FSM state encoding and
// width helpers used by the arbiter, its picker and its checker.
package eth_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int REQ_N_DEF = 4;
  localparam int GRANT_W   = $clog2(REQ_N_DEF);

  // Counter width able to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/eth_tx_arb_chk.sv
// Protocol checker for the requester side of eth_tx_arb: a stalled beat must
// hold its payload, and the byte count never exceeds the beat width.
module eth_tx_arb_chk #(
  parameter int REQ_N  = 4,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 2,
  parameter int KEEP_W = 2
) (
  input logic                    clk_i,
  input logic                    nreset_i,
  input logic [REQ_N-1:0]        req_valid_i,
  input logic [REQ_N*DATA_W-1:0] req_data_i,
  input logic [REQ_N*LEN_W-1:0]  req_len_i,
  input logic [REQ_N-1:0]        req_last_i,
  input logic [REQ_N-1:0]        req_ready_i,
  input logic [REQ_N-1:0]        req_cancel_i
);

  for (genvar r = 0; r < REQ_N; r++) begin : g_req
    // An aborted beat is released, so cancel waives the hold obligation.
    a_hold: assert property (@(posedge clk_i) disable iff (!nreset_i)
      (req_valid_i[r] && !req_ready_i[r] && !req_cancel_i[r]) |=>
      (!req_valid_i[r] ||
       ($stable(req_data_i[r*DATA_W +: DATA_W]) &&
        $stable(req_len_i[r*LEN_W +: LEN_W]) &&
        $stable(req_last_i[r]))));

    a_len: assert property (@(posedge clk_i) disable iff (!nreset_i)
      req_valid_i[r] |-> (int'(req_len_i[r*LEN_W +: LEN_W]) <= KEEP_W));
  end

endmodule

// File: rtl/eth_tx_arb_rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping.
// Kept generic so a future RX dispatcher can reuse it.
module eth_tx_arb_rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  logic found_s;
  int   cand_s;

  // Scan N candidates starting one past the previous winner.
  always_comb begin
    idx_o   = '0;
    found_s = 1'b0;
    cand_s  = 0;
    for (int i = 1; i <= N; i++) begin
      cand_s = (int'(last_i) + i) % N;
      if (!found_s && req_i[cand_s]) begin
        idx_o   = W'(cand_s);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/eth_tx_arb.sv
// Frame-granular round-robin arbiter in front of the shared MAC/IPv4/UDP TX
// stack. Optional starvation watchdog: define ETH_TX_ARB_WDOG_EN.
module eth_tx_arb
  import eth_tx_arb_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int LEN_W    = $clog2(DATA_W / 8 + 1),
  parameter int REQ_N    = 4,
  parameter int GAP_CYC  = 2,
  parameter int WDOG_CYC = 64
) (
  input  logic                       clk,
  input  logic                       nreset,
  input  logic [REQ_N-1:0]           req_valid_i,
  input  logic [REQ_N*DATA_W-1:0]    req_data_i,
  input  logic [REQ_N*LEN_W-1:0]     req_len_i,
  input  logic [REQ_N-1:0]           req_last_i,
  output logic [REQ_N-1:0]           req_ready_o,
  output logic [REQ_N-1:0]           req_cancel_o,
  input  logic                       tx_ready_i,
  input  logic                       tx_cancel_i,
  output logic                       tx_valid_o,
  output logic                       tx_start_o,
  output logic [DATA_W-1:0]          tx_data_o,
  output logic [LEN_W-1:0]           tx_len_o,
  output logic                       tx_last_o,
  output logic [$clog2(REQ_N)-1:0]   grant_o,
  output logic                       busy_o
);

  localparam int     KEEP_W   = DATA_W / 8;
  localparam int     GNT_W    = $clog2(REQ_N);
  localparam int     GAP_W    = cnt_w(GAP_CYC);
  localparam int     GAP_LOAD = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
  localparam state_e END_ST   = (GAP_CYC == 0) ? IDLE : GAP;

  state_e           state_q, state_d;
  logic [GNT_W-1:0] grant_q, grant_d;
  logic [GNT_W-1:0] last_grant_q, last_grant_d;
  logic             first_q, first_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic             valid_g_s, last_g_s, abort_s, accept_s, wdog_hit_s, pick_any_s;
  logic [GNT_W-1:0] pick_idx_s;

  eth_tx_arb_rr_pick #(.N(REQ_N), .W(GNT_W)) u_pick (
    .req_i  (req_valid_i),
    .last_i (last_grant_q),
    .idx_o  (pick_idx_s),
    .any_o  (pick_any_s)
  );

  assign valid_g_s = req_valid_i[grant_q];
  assign last_g_s  = req_last_i[grant_q];
  assign abort_s   = (state_q == XFER) && (tx_cancel_i || wdog_hit_s);
  assign accept_s  = (state_q == XFER) && !abort_s && valid_g_s && tx_ready_i;

`ifdef ETH_TX_ARB_WDOG_EN
  localparam int WDOG_W = cnt_w(WDOG_CYC);
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  // Count owner-idle cycles; any accepted beat or leaving XFER restarts it.
  always_comb begin
    wdog_d = wdog_q;
    if ((state_q != XFER) || abort_s || accept_s) begin
      wdog_d = '0;
    end else if (!valid_g_s) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end else begin
      wdog_d = wdog_q;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  assign wdog_hit_s = (state_q == XFER) && (wdog_q == WDOG_W'(WDOG_CYC));
`else
  assign wdog_hit_s = 1'b0;
`endif

  // Next-state and output decode; an abort overrides the beat path entirely.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    first_d      = first_q;
    gap_d        = gap_q;
    tx_valid_o   = 1'b0;
    tx_start_o   = 1'b0;
    tx_data_o    = '0;
    tx_len_o     = '0;
    tx_last_o    = 1'b0;
    req_ready_o  = '0;
    req_cancel_o = '0;
    case (state_q)
      IDLE: begin
        if (pick_any_s) begin
          grant_d = pick_idx_s;
          first_d = 1'b1;
          state_d = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (abort_s) begin
          req_cancel_o[grant_q] = 1'b1;
          tx_last_o             = wdog_hit_s;
          last_grant_d          = grant_q;
          gap_d                 = GAP_W'(GAP_LOAD);
          state_d               = END_ST;
        end else begin
          tx_valid_o           = valid_g_s;
          tx_start_o           = valid_g_s && first_q;
          tx_data_o            = req_data_i[int'(grant_q)*DATA_W +: DATA_W];
          tx_len_o             = req_len_i[int'(grant_q)*LEN_W +: LEN_W];
          tx_last_o            = last_g_s;
          req_ready_o[grant_q] = tx_ready_i;
          if (accept_s) begin
            first_d = 1'b0;
            if (last_g_s) begin
              last_grant_d = grant_q;
              gap_d        = GAP_W'(GAP_LOAD);
              state_d      = END_ST;
            end else begin
              state_d = XFER;
            end
          end else begin
            state_d = XFER;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; last_grant starts at the top so requester 0 wins first.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GNT_W'(REQ_N - 1);
      first_q      <= 1'b0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      first_q      <= first_d;
      gap_q        <= gap_d;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);

  eth_tx_arb_chk #(
    .REQ_N  (REQ_N),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .KEEP_W (KEEP_W)
  ) u_chk (
    .clk_i        (clk),
    .nreset_i     (nreset),
    .req_valid_i  (req_valid_i),
    .req_data_i   (req_data_i),
    .req_len_i    (req_len_i),
    .req_last_i   (req_last_i),
    .req_ready_i  (req_ready_o),
    .req_cancel_i (req_cancel_o)
  );

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed bench for eth_tx_arb: main instance (4 requesters, gap 2) plus a
// small zero-gap instance for back-to-back framing.
module tb_eth_tx_arb;
  localparam int DW = 16;
  localparam int LW = 2;
  localparam int RN = 4;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  logic [RN-1:0]    req_valid_i, req_last_i, req_ready_o, req_cancel_o;
  logic [RN*DW-1:0] req_data_i;
  logic [RN*LW-1:0] req_len_i;
  logic             tx_ready_i, tx_cancel_i, tx_valid_o, tx_start_o, tx_last_o, busy_o;
  logic [DW-1:0]    tx_data_o;
  logic [LW-1:0]    tx_len_o;
  logic [1:0]       grant_o;

  logic [1:0]    g0_valid, g0_last, g0_ready_o, g0_cancel_o;
  logic [2*DW-1:0] g0_data;
  logic [2*LW-1:0] g0_len;
  logic          g0_tx_ready, g0_tx_cancel, g0_tx_valid, g0_tx_start, g0_tx_last, g0_busy;
  logic [DW-1:0] g0_tx_data;
  logic [LW-1:0] g0_tx_len;
  logic [0:0]    g0_grant;

  int n_checks;
  int n_fail;
  int beat[RN];
  int fno[RN];
  int frames_left[RN];
  int bpf[RN];
  logic [RN-1:0] src_en, acc_s, cxl_s;

  eth_tx_arb #(.DATA_W(DW), .LEN_W(LW), .REQ_N(RN), .GAP_CYC(2), .WDOG_CYC(64)) u_dut (
    .clk(clk), .nreset(nreset),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_len_i(req_len_i),
    .req_last_i(req_last_i), .req_ready_o(req_ready_o), .req_cancel_o(req_cancel_o),
    .tx_ready_i(tx_ready_i), .tx_cancel_i(tx_cancel_i), .tx_valid_o(tx_valid_o),
    .tx_start_o(tx_start_o), .tx_data_o(tx_data_o), .tx_len_o(tx_len_o),
    .tx_last_o(tx_last_o), .grant_o(grant_o), .busy_o(busy_o)
  );

  eth_tx_arb #(.DATA_W(DW), .LEN_W(LW), .REQ_N(2), .GAP_CYC(0), .WDOG_CYC(64)) u_dut_g0 (
    .clk(clk), .nreset(nreset),
    .req_valid_i(g0_valid), .req_data_i(g0_data), .req_len_i(g0_len),
    .req_last_i(g0_last), .req_ready_o(g0_ready_o), .req_cancel_o(g0_cancel_o),
    .tx_ready_i(g0_tx_ready), .tx_cancel_i(g0_tx_cancel), .tx_valid_o(g0_tx_valid),
    .tx_start_o(g0_tx_start), .tx_data_o(g0_tx_data), .tx_len_o(g0_tx_len),
    .tx_last_o(g0_tx_last), .grant_o(g0_grant), .busy_o(g0_busy)
  );

  // Requester r sends beats {r, frame no, beat no}; last beat carries 1 byte.
  task automatic drive_srcs();
    for (int r = 0; r < RN; r++) begin
      req_valid_i[r]          = src_en[r] && (frames_left[r] > 0);
      req_data_i[r*DW +: DW]  = {4'(r), 4'(fno[r]), 8'(beat[r])};
      req_len_i[r*LW +: LW]   = (beat[r] == bpf[r] - 1) ? 2'd1 : 2'd2;
      req_last_i[r]           = (beat[r] == bpf[r] - 1);
    end
  endtask

  task automatic start_srcs();
    drive_srcs();
    #1;
    acc_s = req_valid_i & req_ready_o;
    cxl_s = req_cancel_o;
  endtask

  task automatic cycle(input logic rdy, input logic cxl);
    @(posedge clk);
    #1;
    for (int r = 0; r < RN; r++) begin
      if (cxl_s[r]) begin
        beat[r] = 0; fno[r]++; frames_left[r]--;
      end else if (acc_s[r]) begin
        if (beat[r] == bpf[r] - 1) begin
          beat[r] = 0; fno[r]++; frames_left[r]--;
        end else begin
          beat[r]++;
        end
      end
    end
    tx_ready_i  = rdy;
    tx_cancel_i = cxl;
    drive_srcs();
    #1;
    acc_s = req_valid_i & req_ready_o;
    cxl_s = req_cancel_o;
  endtask

  task automatic do_reset();
    nreset      = 1'b0;
    tx_ready_i  = 1'b1;
    tx_cancel_i = 1'b0;
    for (int r = 0; r < RN; r++) begin
      beat[r] = 0; fno[r] = 0; frames_left[r] = 0; bpf[r] = 1;
    end
    src_en = '1;
    drive_srcs();
    acc_s = '0;
    cxl_s = '0;
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;
  endtask

  task automatic wait_done();
    logic done;
    done = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      cycle(1'b1, 1'b0);
      if (!busy_o && frames_left[0] == 0 && frames_left[1] == 0 &&
          frames_left[2] == 0 && frames_left[3] == 0) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain: busy=%0b still after 80 cycles, expected idle", busy_o);
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0; tx_ready_i = 1'b1; tx_cancel_i = 1'b1;
    for (int r = 0; r < RN; r++) begin
      beat[r] = 0; fno[r] = 0; bpf[r] = 2; frames_left[r] = (r == 1 || r == 2) ? 1 : 0;
    end
    src_en = '1;
    drive_srcs();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid_o); end
    n_checks++; if (tx_start_o !== 1'b0 || tx_last_o !== 1'b0) begin n_fail++; $display("FAIL rst_start_last: got %b%b want 00", tx_start_o, tx_last_o); end
    n_checks++; if (tx_data_o !== 16'h0000 || tx_len_o !== 2'd0) begin n_fail++; $display("FAIL rst_data_len: got %h/%0d want 0000/0", tx_data_o, tx_len_o); end
    n_checks++; if (req_ready_o !== 4'b0000 || req_cancel_o !== 4'b0000) begin n_fail++; $display("FAIL rst_req: got ready %b cancel %b want 0000", req_ready_o, req_cancel_o); end
    n_checks++; if (grant_o !== 2'd0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_grant_busy: got %0d/%b want 0/0", grant_o, busy_o); end
    @(negedge clk);
    nreset = 1'b1;
    #1;
    n_checks++; if (busy_o !== 1'b0 || req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL rst_release: got busy %b ready %b want 0/0000", busy_o, req_ready_o); end
  endtask

  task automatic test_two_frames();
    int ev[10] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
    int es[10] = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    int el[10] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    int eb[10] = '{1, 1, 1, 1, 1, 0, 1, 1, 1, 1};
    logic [15:0] ed[10] = '{16'h0000, 16'h0001, 16'h0002, 16'h0, 16'h0, 16'h0,
                            16'h2000, 16'h2001, 16'h2002, 16'h0};
    do_reset();
    frames_left[0] = 1; bpf[0] = 3;
    frames_left[2] = 1; bpf[2] = 3;
    start_srcs();
    n_checks++; if (tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL arb_latency: got tx_valid %b want 0", tx_valid_o); end
    for (int c = 1; c <= 10; c++) begin
      cycle(1'b1, 1'b0);
      n_checks++;
      if (tx_valid_o !== 1'(ev[c-1]) || tx_start_o !== 1'(es[c-1]) ||
          tx_last_o !== 1'(el[c-1]) || busy_o !== 1'(eb[c-1])) begin
        n_fail++;
        $display("FAIL two_frames_ctl c%0d: got v%b s%b l%b b%b want v%0d s%0d l%0d b%0d",
                 c, tx_valid_o, tx_start_o, tx_last_o, busy_o, ev[c-1], es[c-1], el[c-1], eb[c-1]);
      end
      if (ev[c-1] == 1) begin
        n_checks++;
        if (tx_data_o !== ed[c-1] || tx_len_o !== ((el[c-1] == 1) ? 2'd1 : 2'd2) ||
            grant_o !== ((c < 5) ? 2'd0 : 2'd2)) begin
          n_fail++;
          $display("FAIL two_frames_data c%0d: got %h len %0d grant %0d want %h", c, tx_data_o, tx_len_o, grant_o, ed[c-1]);
        end
      end
      if (c == 1) begin
        n_checks++;
        if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL ungranted_ready: got %b want 0001", req_ready_o); end
      end
    end
    wait_done();
  endtask

  task automatic test_rr_all();
    logic [15:0] ed;
    logic        ev;
    int          g;
    do_reset();
    for (int r = 0; r < RN; r++) begin frames_left[r] = 2; bpf[r] = 1; end
    start_srcs();
    for (int c = 1; c <= 17; c++) begin
      cycle(1'b1, 1'b0);
      ev = ((c - 1) % 4 == 0);
      g  = ((c - 1) / 4) % 4;
      ed = {4'(g), 4'((c - 1) / 16), 8'h00};
      n_checks++;
      if (tx_valid_o !== ev) begin n_fail++; $display("FAIL rr_valid c%0d: got %b want %b", c, tx_valid_o, ev); end
      if (ev) begin
        n_checks++;
        if (grant_o !== 2'(g) || tx_data_o !== ed || tx_start_o !== 1'b1 || tx_last_o !== 1'b1) begin
          n_fail++;
          $display("FAIL rr_grant c%0d: got g%0d %h s%b l%b want g%0d %h s1 l1", c, grant_o, tx_data_o, tx_start_o, tx_last_o, g, ed);
        end
      end
    end
    wait_done();
  endtask

  task automatic test_backpressure();
    logic [15:0] got[$];
    logic        rdy;
    do_reset();
    frames_left[1] = 1; bpf[1] = 4;
    start_srcs();
    for (int c = 1; c <= 12; c++) begin
      rdy = !(c >= 2 && c <= 6);
      cycle(rdy, 1'b0);
      if (tx_valid_o && tx_ready_i) got.push_back(tx_data_o);
      if (c <= 9) begin
        n_checks++;
        if (req_ready_o !== (rdy ? 4'b0010 : 4'b0000)) begin
          n_fail++; $display("FAIL bp_ready c%0d: got %b want %b", c, req_ready_o, rdy ? 4'b0010 : 4'b0000);
        end
      end
    end
    n_checks++;
    if (got.size() != 4) begin
      n_fail++; $display("FAIL bp_count: got %0d beats want 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (got[i] !== {8'h10, 8'(i)}) begin n_fail++; $display("FAIL bp_order %0d: got %h want %h", i, got[i], {8'h10, 8'(i)}); end
      end
    end
    wait_done();
  endtask

  task automatic test_cancel();
    do_reset();
    frames_left[1] = 2; bpf[1] = 4;
    frames_left[2] = 1; bpf[2] = 1;
    start_srcs();
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    n_checks++; if (req_cancel_o !== 4'b0000 || tx_data_o !== 16'h1001) begin n_fail++; $display("FAIL cxl_pre: got cancel %b data %h want 0000/1001", req_cancel_o, tx_data_o); end
    cycle(1'b1, 1'b1);
    n_checks++; if (req_cancel_o !== 4'b0010) begin n_fail++; $display("FAIL cxl_pulse: got %b want 0010", req_cancel_o); end
    n_checks++; if (tx_valid_o !== 1'b0 || req_ready_o !== 4'b0000 || tx_last_o !== 1'b0) begin n_fail++; $display("FAIL cxl_block: got v%b rdy %b l%b want 0/0000/0", tx_valid_o, req_ready_o, tx_last_o); end
    cycle(1'b1, 1'b1);
    n_checks++; if (req_cancel_o !== 4'b0000 || busy_o !== 1'b1) begin n_fail++; $display("FAIL cxl_gap_ignore: got cancel %b busy %b want 0000/1", req_cancel_o, busy_o); end
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    n_checks++;
    if (grant_o !== 2'd2 || tx_valid_o !== 1'b1 || tx_data_o !== 16'h2000 || tx_start_o !== 1'b1) begin
      n_fail++; $display("FAIL cxl_next_grant: got g%0d v%b %h s%b want g2 v1 2000 s1", grant_o, tx_valid_o, tx_data_o, tx_start_o);
    end
    wait_done();
  endtask

  task automatic test_stall_hold();
    do_reset();
    frames_left[3] = 1; bpf[3] = 3;
    start_srcs();
    cycle(1'b1, 1'b0);
    n_checks++; if (grant_o !== 2'd3 || tx_data_o !== 16'h3000) begin n_fail++; $display("FAIL stall_first: got g%0d %h want g3 3000", grant_o, tx_data_o); end
    src_en[3] = 1'b0;
    for (int c = 2; c <= 71; c++) begin
      cycle(1'b1, 1'b0);
`ifdef ETH_TX_ARB_WDOG_EN
      if (c == 66) begin
        n_checks++;
        if (req_cancel_o !== 4'b1000 || tx_last_o !== 1'b1 || tx_valid_o !== 1'b0) begin
          n_fail++; $display("FAIL wdog_abort: got cancel %b l%b v%b want 1000/1/0", req_cancel_o, tx_last_o, tx_valid_o);
        end
      end else if (c < 66) begin
        n_checks++;
        if (req_cancel_o !== 4'b0000) begin n_fail++; $display("FAIL wdog_early c%0d: got %b want 0000", c, req_cancel_o); end
      end else begin
        src_en[3] = 1'b1;
      end
`else
      n_checks++;
      if (busy_o !== 1'b1 || grant_o !== 2'd3 || tx_valid_o !== 1'b0 || req_cancel_o !== 4'b0000) begin
        n_fail++; $display("FAIL stall_hold c%0d: got b%b g%0d v%b cxl %b want 1/3/0/0000", c, busy_o, grant_o, tx_valid_o, req_cancel_o);
      end
`endif
    end
    src_en[3] = 1'b1;
    wait_done();
  endtask

  task automatic test_gap0();
    logic ev;
    do_reset();
    g0_valid = 2'b01; g0_last = 2'b01; g0_data = {16'h0000, 16'hA5A5};
    g0_len = {2'd0, 2'd2}; g0_tx_ready = 1'b1; g0_tx_cancel = 1'b0;
    #1;
    n_checks++; if (g0_tx_valid !== 1'b0) begin n_fail++; $display("FAIL g0_idle: got %b want 0", g0_tx_valid); end
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #2;
      ev = (c % 2 == 1);
      n_checks++;
      if (g0_tx_valid !== ev || g0_busy !== ev) begin
        n_fail++; $display("FAIL g0_b2b c%0d: got v%b b%b want %b", c, g0_tx_valid, g0_busy, ev);
      end
      if (ev) begin
        n_checks++;
        if (g0_tx_data !== 16'hA5A5 || g0_tx_start !== 1'b1 || g0_tx_last !== 1'b1 || g0_grant !== 1'b0) begin
          n_fail++; $display("FAIL g0_beat c%0d: got %h s%b l%b g%0d want a5a5 s1 l1 g0", c, g0_tx_data, g0_tx_start, g0_tx_last, g0_grant);
        end
      end
    end
    @(posedge clk);
    #1;
    g0_valid = 2'b00;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    g0_valid = 2'b00; g0_last = 2'b00; g0_data = '0; g0_len = '0;
    g0_tx_ready = 1'b0; g0_tx_cancel = 1'b0;
    test_reset();
    test_two_frames();
    test_rr_all();
    test_backpressure();
    test_cancel();
    test_stall_hold();
    test_gap0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
